// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : counter_pkg
// Brief   : Shared state encoding and default width for the display counter.
// Revision: 1.0
// ============================================================================
package counter_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : tick_gen
// Brief   : Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Revision: 1.0
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int            c_PW   = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0] c_LAST = c_PW'(TICK_DIV - 1);

    logic [c_PW-1:0] r_pre;

    always_ff @(posedge clk100_i) begin
        if (rst_i || clr_i) begin
            r_pre <= '0;
        end else if (en_i) begin
            if (r_pre == c_LAST) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + c_PW'(1);
            end
        end
    end

    // Tick is decoded from the register so the step lands on the wrap edge.
    assign tick_o = en_i && (r_pre == c_LAST);

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : counter_ctrl
// Brief   : Display counter sequencer: manual/auto stepping, wrap or one-shot.
// Revision: 1.0
// ============================================================================
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int               CNT_W     = CNT_W_DEF,
    parameter int               TICK_DIV  = 100000000,
    parameter logic [CNT_W-1:0] RESET_VAL = CNT_W'(55)
) (
    input  logic             clk100_i,
    input  logic             rst_i,
    input  logic             step_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dir_i,
    input  logic             oneshot_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [1:0]       state_o,
    output logic             wrap_o,
    output logic             done_o
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;
    logic             r_done;

    logic [CNT_W-1:0] w_next;
    logic [CNT_W-1:0] w_load;
    logic             w_wrap;
    logic             w_tick;
    logic             w_clr;
    logic             w_run;

    always_comb begin
        w_next = r_cnt;
        w_wrap = 1'b0;
        if (!dir_i) begin
            if (r_cnt >= limit_i) begin
                w_next = '0;
                w_wrap = 1'b1;
            end else begin
                w_next = r_cnt + CNT_W'(1);
            end
        end else begin
            if (r_cnt == '0) begin
                w_next = limit_i;
                w_wrap = 1'b1;
            end else if (r_cnt > limit_i) begin
                w_next = limit_i;
            end else begin
                w_next = r_cnt - CNT_W'(1);
            end
        end
    end

    assign w_load = (load_val_i < limit_i) ? load_val_i : limit_i;
    assign w_run  = (r_state == ST_RUN);
    assign w_clr  = load_i || (mode_i && (r_state == ST_IDLE));

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk100_i (clk100_i),
        .rst_i    (rst_i),
        .clr_i    (w_clr),
        .en_i     (w_run),
        .tick_o   (w_tick)
    );

    // Priority: reset > load > mode > step source; losers are simply dropped.
    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            r_cnt   <= RESET_VAL;
            r_state <= ST_IDLE;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (load_i) begin
                r_cnt   <= w_load;
                r_state <= ST_IDLE;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (mode_i) begin
                            r_state <= ST_RUN;
                        end else if (step_i) begin
                            r_cnt  <= w_next;
                            r_wrap <= w_wrap;
                        end
                    end
                    ST_RUN: begin
                        if (mode_i) begin
                            r_state <= ST_IDLE;
                        end else if (w_tick) begin
                            if (oneshot_i && w_wrap) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_cnt  <= w_next;
                                r_wrap <= w_wrap;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (mode_i) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cnt_o   = r_cnt;
    assign state_o = r_state;
    assign wrap_o  = r_wrap;
    assign done_o  = r_done;

endmodule
`default_nettype wire

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencer for the board's 8-bit display counter. It accepts one-cycle button pulses from the debouncer, plus load, direction and limit settings taken from the switches. It applies each counter step either manually (IDLE) or from an internal prescaled tick (RUN), with wrap or one-shot stop at a programmable limit. It sits between the debounced key/switch inputs and the hex decoders, and owns the counter register.

Parameters:
CNT_W, 8, counter width in bits
TICK_DIV, 100000000, clk100_i cycles per auto-step in RUN (1 s at 100 MHz); must be >= 2
RESET_VAL, 8'd55, counter value after reset

Ports:
clk100_i  input  1  system clock, 100 MHz
rst_i  input  1  reset, synchronous, active-high
step_i  input  1  one-cycle pulse: manual step request
mode_i  input  1  one-cycle pulse: toggle IDLE/RUN; leave DONE
load_i  input  1  one-cycle pulse: load load_val_i
load_val_i  input  CNT_W  value to load
dir_i  input  1  0 = count up, 1 = count down; level, sampled at each step
oneshot_i  input  1  1 = stop in DONE at the limit instead of wrapping (RUN only)
limit_i  input  CNT_W  upper bound of the count range [0, limit_i]
cnt_o  output  CNT_W  counter value, registered
state_o  output  2  FSM state: 0 IDLE, 1 RUN, 2 DONE
wrap_o  output  1  one-cycle pulse: a step wrapped
done_o  output  1  high while in DONE

Behaviour:
- All outputs are registered. Any accepted input updates the outputs on the next clk100_i edge, i.e. 1-cycle latency.
- Reset (rst_i=1 at a clock edge):
  - cnt_o=RESET_VAL, state IDLE, wrap_o=0, done_o=0, prescaler=0.
  - rst_i overrides all other inputs.
  - Reset mid-RUN aborts the run immediately.
- Step rule, up (dir_i=0):
  - cnt >= limit_i -> cnt=0 and wrap_o pulses.
  - Otherwise cnt+1.
- Step rule, down (dir_i=1):
  - cnt == 0 -> cnt=limit_i and wrap_o pulses.
  - cnt > limit_i -> cnt=limit_i, no wrap.
  - Otherwise cnt-1.
- All arithmetic is CNT_W-bit unsigned.
- Same-cycle priority: rst_i > load_i > mode_i > step source. A lower-priority event arriving in the same cycle is dropped, not queued.
- load_i, in any state:
  - cnt = min(load_val_i, limit_i); state goes to IDLE; prescaler cleared; no wrap pulse.
- IDLE:
  - step_i applies one step.
  - mode_i goes to RUN and clears the prescaler.
- RUN:
  - step_i is ignored.
  - The prescaler counts 0..TICK_DIV-1; a tick occurs when prescaler == TICK_DIV-1, then it returns to 0.
  - The first step is therefore applied TICK_DIV cycles after the mode_i pulse.
  - mode_i goes to IDLE; a tick in that same cycle is dropped.
  - If oneshot_i=1 and a tick's step would wrap: the step is not applied, cnt holds, wrap_o stays 0, state goes to DONE.
- DONE:
  - done_o=1; cnt holds; step_i and ticks are ignored.
  - mode_i goes to IDLE.
- The prescaler does not advance outside RUN.
- wrap_o is high only in the cycle after a wrapping step.
- limit_i and dir_i may change at any time; they take effect at the next step.

Decomposition:
- Shared package counter_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default CNT_W.
- One sub-module, tick_gen, implements the prescaler.
  - Parameter: TICK_DIV.
  - Inputs: clk100_i, rst_i, clr_i, en_i.
  - Output: tick_o, a one-cycle pulse.
- The FSM and the step datapath stay in counter_ctrl.

Test Plan (TICK_DIV=4):
1. Reset: rst_i=1 for 2 cycles -> cnt_o=55, state_o=0, wrap_o=0, done_o=0; step_i held during reset has no effect.
2. IDLE manual up, limit_i=57: three step_i pulses -> cnt_o 56, 57, 0; wrap_o pulses only after the third.
3. RUN down, limit_i=9: load 2, then mode_i -> cnt_o=1 at +4 cycles, 0 at +8, 9 at +12 with a wrap_o pulse; step_i pulses during RUN are ignored.
4. One-shot up, limit_i=3, oneshot_i=1: load 2, then mode_i -> cnt_o=3 at +4; at +8 state_o=2, done_o=1, cnt_o stays 3, wrap_o=0; mode_i -> state_o=0.
5. Collisions:
   - load_i, mode_i and step_i in the same cycle during RUN -> cnt_o=load value, state IDLE, no step.
   - mode_i coinciding with a tick -> state IDLE, cnt_o unchanged.
6. Clamp and abort:
   - load_val_i=200 with limit_i=100 -> cnt_o=100.
   - rst_i asserted mid-RUN -> cnt_o=55, state IDLE, the next tick never occurs.
